// File: rtl/a51_sequencer.sv
// a51_sequencer: phase controller driving an A5/1 core through clear, key load, frame load, mixing and keystream output.
// Optional macro A51_FRAME_AUTOINC_EN: start held in DONE relaunches with frame_l+1 and the retained key.
module a51_sequencer #(
    parameter int unsigned KEY_BITS   = 64,
    parameter int unsigned FRAME_BITS = 22,
    parameter int unsigned MIX_CYCLES = 100,
    parameter int unsigned KS_BITS    = 228,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  ks_ready,
    output logic                  core_clr,
    output logic                  core_step,
    output logic                  core_force,
    output logic                  core_in_bit,
    output logic                  ks_valid,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            stage
);

    localparam int unsigned KIW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam int unsigned FIW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_KEY,
        S_FRAME,
        S_MIX,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [KEY_BITS-1:0]   key_l;
    logic [FRAME_BITS-1:0] frame_l;

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            key_l   <= '0;
            frame_l <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_l   <= key;
                        frame_l <= frame;
                        cnt     <= '0;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt   <= '0;
                    state <= S_KEY;
                end
                S_KEY: begin
                    if (cnt == KEY_LAST) begin
                        cnt   <= '0;
                        state <= S_FRAME;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FRAME: begin
                    if (cnt == FRAME_LAST) begin
                        cnt   <= '0;
                        state <= S_MIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_MIX: begin
                    if (cnt == MIX_LAST) begin
                        cnt   <= '0;
                        state <= S_OUTPUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    // Counter only advances on an accepted keystream bit.
                    if (ks_ready) begin
                        if (cnt == KS_LAST) begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cnt   <= '0;
                    state <= S_IDLE;
`ifdef A51_FRAME_AUTOINC_EN
                    if (start) begin
                        frame_l <= frame_l + 1'b1;
                        state   <= S_CLEAR;
                    end
`endif
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        core_clr    = clr;
        core_step   = 1'b0;
        core_force  = 1'b0;
        core_in_bit = 1'b0;
        ks_valid    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        stage       = '0;
        case (state)
            S_CLEAR: begin
                core_clr = 1'b1;
                busy     = 1'b1;
            end
            S_KEY: begin
                core_step   = 1'b1;
                core_force  = 1'b1;
                core_in_bit = key_l[cnt[KIW-1:0]];
                busy        = 1'b1;
                stage       = 4'b0001;
            end
            S_FRAME: begin
                core_step   = 1'b1;
                core_force  = 1'b1;
                core_in_bit = frame_l[cnt[FIW-1:0]];
                busy        = 1'b1;
                stage       = 4'b0010;
            end
            S_MIX: begin
                core_step = 1'b1;
                busy      = 1'b1;
                stage     = 4'b0100;
            end
            S_OUTPUT: begin
                core_step = ks_ready;
                ks_valid  = 1'b1;
                busy      = 1'b1;
                stage     = 4'b1000;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                core_step = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_a51_sequencer.sv
// Self-checking bench for a51_sequencer: timeline reference model, boundary table and directed corner sequences.
module tb_a51_sequencer;

    localparam int KB      = 64;
    localparam int FB      = 22;
    localparam int MIXC    = 100;
    localparam int KSB     = 228;
    localparam int P_KEY   = 2;
    localparam int P_FRAME = P_KEY + KB;
    localparam int P_MIX   = P_FRAME + FB;
    localparam int P_OUT   = P_MIX + MIXC;

    logic          clk = 1'b0;
    logic          clr, start, ks_ready;
    logic [KB-1:0] key;
    logic [FB-1:0] frame;
    logic          core_clr, core_step, core_force, core_in_bit, ks_valid, busy, done;
    logic [3:0]    stage;

    always #5 clk = ~clk;

    a51_sequencer #(
        .KEY_BITS(KB), .FRAME_BITS(FB), .MIX_CYCLES(MIXC), .KS_BITS(KSB), .CNT_W(8)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .key(key), .frame(frame), .ks_ready(ks_ready),
        .core_clr(core_clr), .core_step(core_step), .core_force(core_force),
        .core_in_bit(core_in_bit), .ks_valid(ks_valid), .busy(busy), .done(done), .stage(stage)
    );

    int checks = 0;
    int errors = 0;
    int rc = 0;

    // Reference model: a run is a timeline of elapsed cycles t and accepted bits n.
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
    mmode_t        m_mode = M_IDLE;
    int            m_t = 0, m_n = 0;
    logic [KB-1:0] m_key = '0;
    logic [FB-1:0] m_frame = '0;
    bit            mdl_en = 0;

    typedef struct {
        int         cyc;
        logic [3:0] stg;
        logic       bsy;
        logic       dn;
        logic       cclr;
        logic       kval;
    } vec_t;
    localparam int NT = 11;
    vec_t tbl[NT];
    bit   tbl_on = 0;
    int   ti = 0;
    bit   cap_on = 0;
    logic [P_MIX-P_KEY-1:0] capbits;

    function automatic logic [10:0] outs();
        return {core_clr, core_step, core_force, core_in_bit, ks_valid, busy, done, stage};
    endfunction

    function automatic logic [10:0] model_exp();
        logic cc, st, fo, ib, kv, bz, dn;
        logic [3:0] sg;
        {cc, st, fo, ib, kv, bz, dn} = '0;
        sg = '0;
        if (m_mode == M_RUN) begin
            bz = 1'b1;
            if (m_t < P_KEY) begin
                cc = 1'b1;
            end else if (m_t < P_FRAME) begin
                st = 1'b1; fo = 1'b1; ib = m_key[m_t - P_KEY]; sg = 4'b0001;
            end else if (m_t < P_MIX) begin
                st = 1'b1; fo = 1'b1; ib = m_frame[m_t - P_FRAME]; sg = 4'b0010;
            end else if (m_t < P_OUT) begin
                st = 1'b1; sg = 4'b0100;
            end else begin
                kv = 1'b1; st = ks_ready; sg = 4'b1000;
            end
        end else if (m_mode == M_DONE) begin
            dn = 1'b1;
        end
        cc = cc | clr;
        return {cc, st, fo, ib, kv, bz, dn, sg};
    endfunction

    task automatic model_step();
        if (clr) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_key = key; m_frame = frame; m_mode = M_RUN; m_t = 1; m_n = 0;
                end
                M_RUN: begin
                    if (m_t >= P_OUT && ks_ready) begin
                        m_n++;
                        if (m_n == KSB) m_mode = M_DONE;
                    end
                    m_t++;
                end
                default: begin
                    m_mode = M_IDLE;
`ifdef A51_FRAME_AUTOINC_EN
                    if (start) begin
                        m_frame = m_frame + 1'b1; m_mode = M_RUN; m_t = 1; m_n = 0;
                    end
`endif
                end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d, t=%0t)", name, got, exp, rc, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (mdl_en) check("model_outputs", 128'(outs()), 128'(model_exp()));
        if (tbl_on && ti < NT && tbl[ti].cyc == rc) begin
            check($sformatf("tbl_cyc%0d", tbl[ti].cyc),
                  128'({stage, busy, done, core_clr, ks_valid}),
                  128'({tbl[ti].stg, tbl[ti].bsy, tbl[ti].dn, tbl[ti].cclr, tbl[ti].kval}));
            ti++;
        end
        if (cap_on && rc >= P_KEY && rc < P_MIX) capbits[rc - P_KEY] = core_in_bit;
        @(posedge clk);
        model_step();
        mdl_en = 1;
        rc++;
        #1;
    endtask

    initial begin
        int first_out, done_at, xfers, d1, c2;
        bit seen_done;

        tbl[0]  = '{1,   4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{2,   4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{65,  4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{66,  4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{87,  4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{88,  4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{187, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{188, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{415, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{416, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{417, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};

        clr = 1'b1; start = 1'b0; ks_ready = 1'b0; key = '0; frame = '0;
        cycle();
        cycle();
        check("reset_outputs", 128'(outs()), 128'(11'h400));
        clr = 1'b0;
        cycle();
        check("idle_outputs", 128'(outs()), 128'(0));

        // Nominal run with the reference key/frame and ready tied high.
        key = 64'h1223456789ABCDEF; frame = 22'h134; ks_ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0; rc = 1; ti = 0; tbl_on = 1; cap_on = 1;
        key = '1; frame = '1;
        repeat (420) cycle();
        tbl_on = 0; cap_on = 0;
        check("tbl_entries_hit", 128'(ti), 128'(NT));
        check("in_bit_sequence", 128'(capbits), 128'({22'h134, 64'h1223456789ABCDEF}));

        // Back-pressure: ready low on the OUTPUT entry cycle, then alternating.
        key = 64'hA5A5_0F0F_3C3C_9696; frame = 22'h2AAAA; start = 1'b1;
        cycle();
        start = 1'b0; rc = 1;
        first_out = -1; done_at = -1; xfers = 0;
        for (int i = 0; i < 700 && done_at < 0; i++) begin
            ks_ready = rc[0];
            #1;
            if (ks_valid && first_out < 0) first_out = rc;
            if (ks_valid && ks_ready) xfers++;
            if (done) done_at = rc;
            cycle();
        end
        ks_ready = 1'b1;
        check("toggle_out_entry", 128'(first_out), 128'(P_OUT));
        check("toggle_transfers", 128'(xfers), 128'(KSB));
        check("toggle_done_gap", 128'(done_at - first_out), 128'(456));

        // clr in the middle of MIX abandons the run.
        start = 1'b1;
        cycle();
        start = 1'b0; rc = 1;
        repeat (119) cycle();
        check("clr_cycle_in_mix", 128'(stage), 128'(4'b0100));
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        #1;
        check("clr_idle_outputs", 128'(outs()), 128'(0));
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen_done = 1;
            cycle();
        end
        check("no_done_after_clr", 128'(seen_done), 128'(0));
        start = 1'b1;
        cycle();
        start = 1'b0; rc = 1;
        repeat (415) cycle();
        check("rerun_done_416", 128'({done, busy}), 128'(2'b10));
        cycle();

        // start and clr on the same edge: clr wins.
        start = 1'b1; clr = 1'b1;
        cycle();
        start = 1'b0; clr = 1'b0;
        #1;
        check("start_clr_same_edge", 128'({busy, stage, core_clr}), 128'(0));
        cycle();
        check("start_clr_stays_idle", 128'(busy), 128'(0));

        // start held high: gap between done and next CLEAR.
        frame = 22'h3FFFFF; start = 1'b1;
        d1 = -1; c2 = -1;
        for (int i = 0; i < 1000 && c2 < 0; i++) begin
            #1;
            if (done && d1 < 0) d1 = i;
            if (d1 >= 0 && core_clr && busy && c2 < 0) c2 = i;
            cycle();
        end
`ifdef A51_FRAME_AUTOINC_EN
        check("held_start_gap", 128'(c2 - d1), 128'(1));
`else
        check("held_start_gap", 128'(c2 - d1), 128'(2));
`endif
        repeat (120) cycle();
        start = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0;

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 3000; i++) begin
            key      = {$urandom, $urandom};
            frame    = FB'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            ks_ready = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 699) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
